pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset/lock sequencer for the 50 MHz-referenced clock-generation PLL (200 MHz and 10 MHz outputs). Runs on the free-running reference clock. It drives the PLL reset, qualifies the PLL lock indication, retries failed acquisitions and releases a single system reset only after lock has been stable. On loss of lock it reasserts the system reset and restarts the PLL.

## Interface
Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 5000: cycles allowed from pll_rst release to reaching RUN (≥ STABLE_CYCLES+4).
- STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before releasing sys_rst (≥1).
- MAX_RETRIES, 3: acquisition attempts after the first before declaring fault.

Ports:
- refclk  in  1  50 MHz reference clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL locked output, asynchronous to refclk.
- restart  in  1  single-cycle request to restart the sequence from any state.
- pll_rst  out  1  reset to the PLL rst port.
- sys_rst  out  1  active-high reset to logic in the PLL output domains.
- running  out  1  high in RUN.
- fault  out  1  high in FAULT.
- lock_lost  out  1  one-cycle pulse on loss of lock in RUN.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  failed attempts in the current acquisition.

## Operation
- pll_locked passes through a 2-flop synchronizer; the FSM sees only lk_s.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT.
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - Counts RST_CYCLES cycles, then goes to WAIT_LOCK.
  - The timeout counter clears on exit.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - The timeout counter increments every cycle.
  - lk_s=1 goes to STABLE with the stable counter at 0.
- STABLE:
  - The stable counter increments while lk_s=1.
  - lk_s=0 returns to WAIT_LOCK. The stable counter clears; the timeout counter keeps counting.
  - The counter reaching STABLE_CYCLES goes to RUN.
- Timeout: the timeout counter reaching LOCK_TIMEOUT in WAIT_LOCK or STABLE counts as a failed attempt.
  - If retry_cnt < MAX_RETRIES: retry_cnt increments and the FSM goes to RESET_PLL.
  - Otherwise: go to FAULT.
  - A timeout in the same cycle as stable completion: RUN wins.
- RUN:
  - pll_rst=0, sys_rst=0, running=1, retry_cnt cleared on entry.
  - lk_s=0 pulses lock_lost for 1 cycle and goes to RESET_PLL.
  - Loss of lock in RUN does not increment retry_cnt.
- FAULT: pll_rst=1, sys_rst=1, fault=1. Leaves only on restart or rst.
- restart: from any state, the next state is RESET_PLL with retry_cnt=0. restart takes priority over all other transitions in that cycle.
- Outputs are registered, decoded from the next state, so they change in the same cycle the state changes.

## Timing
- Reset values: pll_rst=1, sys_rst=1, running=0, fault=0, lock_lost=0, retry_cnt=0. State is RESET_PLL with counters at 0. Synchronizer flops are 0.
- rst mid-operation: all of the above values apply on the next edge, including from RUN. sys_rst rises immediately and lock_lost does not pulse.
- pll_locked → lk_s latency is 2 cycles.
- lk_s rise → sys_rst fall takes STABLE_CYCLES+1 cycles, if no drop occurs.
- In RUN, pll_locked falling → sys_rst high takes 3 cycles: 2 synchronizer cycles plus 1 register cycle. lock_lost is high in that same cycle.
- A full attempt with no lock lasts RST_CYCLES + LOCK_TIMEOUT cycles.

## Structure
- Package pll_seq_pkg holds:
  - the state enum (st_e);
  - the synchronizer depth constant (SYNC_STAGES=2).
- Sub-module pll_lock_sync: the parameterized-depth bit synchronizer. Inputs refclk, rst, d; output q.
- Everything else lives in pll_reset_seq: FSM, three counters, output registers.

## Test plan
Use RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: raise pll_locked 10 cycles after pll_rst falls → sys_rst falls at lk_s rise + 9 cycles, running=1, retry_cnt=0.
- Glitchy lock: pll_locked high 5 cycles, low 2, then high → stable count restarts. sys_rst releases 9 cycles after the second lk_s rise, and the timeout counter is not reset.
- Never lock: pll_locked held 0 → pll_rst pulses 3 times (4 cycles each), retry_cnt goes 1 then 2. fault rises at cycle 312 after rst release (3×104); pll_rst=1 and sys_rst=1 stay held.
- Loss in RUN: drop pll_locked → lock_lost is a 1-cycle pulse and sys_rst=1 at drop+3 cycles. pll_rst is high for 4 cycles, then relock reaches RUN again with retry_cnt=0.
- Restart and reset: pulse restart in FAULT → RESET_PLL with retry_cnt=0 and fault=0. Assert rst in STABLE → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } st_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag into the refclk domain.
module pll_lock_sync
    import pll_seq_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // NOTE: the chain is reset so lk_s reads a known "unlocked" value right after reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, retries failed
// acquisitions and releases the system reset once lock has been stable.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 5000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             restart,
    output logic                             pll_rst,
    output logic                             sys_rst,
    output logic                             running,
    output logic                             fault,
    output logic                             lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

    localparam int RW  = $clog2(MAX_RETRIES + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TCW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);

    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(LOCK_TIMEOUT - 1);
    localparam logic [SCW-1:0] STB_LAST  = SCW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

    st_e            state;
    st_e            nxt;
    st_e            fail_nxt;
    logic           lk_s;
    logic           timeout;
    logic           retry_inc;
    logic [RCW-1:0] rst_cnt;
    logic [TCW-1:0] to_cnt;
    logic [SCW-1:0] st_cnt;

    pll_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (pll_locked),
        .q      (lk_s)
    );

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        nxt       = state;
        timeout   = (state == WAIT_LOCK || state == STABLE) && (to_cnt == TO_LAST);
        fail_nxt  = (retry_cnt < RETRY_MAX) ? RESET_PLL : FAULT;
        case (state)
            RESET_PLL: if (rst_cnt == RST_LAST) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (timeout)   nxt = fail_nxt;
                else if (lk_s) nxt = STABLE;
            end
            // Stable completion beats a coincident timeout.
            STABLE: begin
                if (lk_s && st_cnt == STB_LAST) nxt = RUN;
                else if (timeout)               nxt = fail_nxt;
                else if (!lk_s)                 nxt = WAIT_LOCK;
            end
            RUN:       if (!lk_s) nxt = RESET_PLL;
            FAULT:     nxt = FAULT;
            default:   nxt = RESET_PLL;
        endcase
        retry_inc = timeout && (nxt == RESET_PLL);
        if (restart) nxt = RESET_PLL;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= RESET_PLL;
            rst_cnt   <= '0;
            to_cnt    <= '0;
            st_cnt    <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            running   <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state   <= nxt;
            rst_cnt <= (state == RESET_PLL && nxt == RESET_PLL && !restart) ? rst_cnt + 1'b1 : '0;
            st_cnt  <= (state == STABLE && nxt == STABLE) ? st_cnt + 1'b1 : '0;

            // The timeout spans the whole attempt, so a STABLE->WAIT_LOCK bounce keeps it running.
            if (restart || !(state == WAIT_LOCK || state == STABLE)) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (restart || (nxt == RUN && state != RUN)) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            pll_rst   <= (nxt == RESET_PLL) || (nxt == FAULT);
            sys_rst   <= (nxt != RUN);
            running   <= (nxt == RUN);
            fault     <= (nxt == FAULT);
            lock_lost <= (state == RUN) && !lk_s && !restart;
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: scenario tasks push cycle-stamped expected
// output vectors to a scoreboard that a negedge monitor pops and compares.
module tb_pll_reset_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_rst, running, fault, lock_lost;
    logic [1:0] retry_cnt;

    // Expected vector layout: {pll_rst, sys_rst, running, fault, lock_lost, retry_cnt[1:0]}
    typedef struct {
        string      name;
        int         cyc;
        int         rel;
        logic [6:0] v;
    } exp_t;

    exp_t       sb[$];
    exp_t       chk_e;
    logic [6:0] chk_obs;
    int         cyc = 0;
    int         t0 = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    pll_reset_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .running    (running),
        .fault      (fault),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    always #10 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    // Scoreboard monitor: outputs are sampled on the falling edge, after edge number cyc.
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk_e   = sb.pop_front();
            chk_obs = {pll_rst, sys_rst, running, fault, lock_lost, retry_cnt};
            n_checks++;
            if (chk_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d was missed (now %0d)", chk_e.name, chk_e.cyc, cyc);
            end else if (chk_obs !== chk_e.v) begin
                n_fail++;
                $display("FAIL %s @rel %0d: {pll_rst,sys_rst,running,fault,lock_lost,retry} got %b expected %b",
                         chk_e.name, chk_e.rel, chk_obs, chk_e.v);
            end
        end
    end

    task automatic expect_at(input string nm, input int j, input logic pr, input logic sr,
                             input logic rn, input logic ft, input logic ll, input logic [1:0] rc);
        exp_t e;
        e.name = nm;
        e.cyc  = t0 + j;
        e.rel  = j;
        e.v    = {pr, sr, rn, ft, ll, rc};
        sb.push_back(e);
    endtask

    task automatic goto(input int j);
        while (cyc < t0 + j) @(negedge refclk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge refclk);
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations never reached within %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    // Holds rst for two edges; afterwards relative edge 1 is the first edge with rst low.
    task automatic apply_reset();
        @(negedge refclk);
        rst     = 1'b1;
        restart = 1'b0;
        t0      = cyc;
        expect_at("reset_values", 1, 1, 1, 0, 0, 0, 2'd0);
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        t0  = cyc;
    endtask

    task automatic test_reset();
        pll_locked = 1'b0;
        apply_reset();
        expect_at("rst_pll_held",     3, 1, 1, 0, 0, 0, 2'd0);
        expect_at("rst_pll_released", 4, 0, 1, 0, 0, 0, 2'd0);
        wait_drain(20);
    endtask

    task automatic test_clean_lock();
        pll_locked = 1'b0;
        apply_reset();
        // pll_rst falls at edge 4, lock at +10, lk_s rises at edge 16, RUN at 16+9.
        expect_at("clean_pre_run", 24, 0, 1, 0, 0, 0, 2'd0);
        expect_at("clean_run",     25, 0, 0, 1, 0, 0, 2'd0);
        expect_at("clean_hold",    30, 0, 0, 1, 0, 0, 2'd0);
        goto(14); pll_locked = 1'b1;
        goto(30);
        wait_drain(10);
    endtask

    task automatic test_glitchy_lock();
        pll_locked = 1'b0;
        apply_reset();
        // Second lk_s rise lands at edge 23, so RUN at 32.
        expect_at("glitch_pre_run", 31, 0, 1, 0, 0, 0, 2'd0);
        expect_at("glitch_run",     32, 0, 0, 1, 0, 0, 2'd0);
        goto(14); pll_locked = 1'b1;
        goto(19); pll_locked = 1'b0;
        goto(21); pll_locked = 1'b1;
        goto(32);
        wait_drain(10);
    endtask

    task automatic test_timeout_persists();
        pll_locked = 1'b0;
        apply_reset();
        // Late glitchy lock: RUN would be at 106 but the unbroken timeout fires at 104.
        expect_at("late_pre_timeout", 103, 0, 1, 0, 0, 0, 2'd0);
        expect_at("late_retry",       104, 1, 1, 0, 0, 0, 2'd1);
        expect_at("late_pll_rst",     107, 1, 1, 0, 0, 0, 2'd1);
        expect_at("late_wait",        108, 0, 1, 0, 0, 0, 2'd1);
        expect_at("late_pre_run",     116, 0, 1, 0, 0, 0, 2'd1);
        expect_at("late_run",         117, 0, 0, 1, 0, 0, 2'd0);
        goto(88); pll_locked = 1'b1;
        goto(93); pll_locked = 1'b0;
        goto(95); pll_locked = 1'b1;
        goto(117);
        wait_drain(10);
    endtask

    task automatic test_never_lock_and_restart();
        pll_locked = 1'b0;
        apply_reset();
        expect_at("never_wait1",    4, 0, 1, 0, 0, 0, 2'd0);
        expect_at("never_pre_to1",  103, 0, 1, 0, 0, 0, 2'd0);
        expect_at("never_retry1",   104, 1, 1, 0, 0, 0, 2'd1);
        expect_at("never_pll_rst1", 107, 1, 1, 0, 0, 0, 2'd1);
        expect_at("never_wait2",    108, 0, 1, 0, 0, 0, 2'd1);
        expect_at("never_pre_to2",  207, 0, 1, 0, 0, 0, 2'd1);
        expect_at("never_retry2",   208, 1, 1, 0, 0, 0, 2'd2);
        expect_at("never_wait3",    212, 0, 1, 0, 0, 0, 2'd2);
        expect_at("never_pre_fault",311, 0, 1, 0, 0, 0, 2'd2);
        expect_at("never_fault",    312, 1, 1, 0, 1, 0, 2'd2);
        expect_at("fault_held",     350, 1, 1, 0, 1, 0, 2'd2);
        expect_at("restart_enter",  361, 1, 1, 0, 0, 0, 2'd0);
        expect_at("restart_pll_rst",364, 1, 1, 0, 0, 0, 2'd0);
        expect_at("restart_wait",   365, 0, 1, 0, 0, 0, 2'd0);
        goto(360); restart = 1'b1;
        goto(361); restart = 1'b0;
        goto(365);
        wait_drain(10);
    endtask

    task automatic test_loss_in_run();
        pll_locked = 1'b0;
        apply_reset();
        expect_at("loss_run",        25, 0, 0, 1, 0, 0, 2'd0);
        expect_at("loss_pre_drop",   42, 0, 0, 1, 0, 0, 2'd0);
        expect_at("loss_pulse",      43, 1, 1, 0, 0, 1, 2'd0);
        expect_at("loss_pulse_end",  44, 1, 1, 0, 0, 0, 2'd0);
        expect_at("loss_pll_rst",    46, 1, 1, 0, 0, 0, 2'd0);
        expect_at("loss_wait",       47, 0, 1, 0, 0, 0, 2'd0);
        expect_at("relock_pre_run",  60, 0, 1, 0, 0, 0, 2'd0);
        expect_at("relock_run",      61, 0, 0, 1, 0, 0, 2'd0);
        goto(14); pll_locked = 1'b1;
        goto(40); pll_locked = 1'b0;
        goto(50); pll_locked = 1'b1;
        goto(61);
        wait_drain(10);
    endtask

    task automatic test_rst_in_stable();
        pll_locked = 1'b0;
        apply_reset();
        expect_at("stable_before_rst", 20, 0, 1, 0, 0, 0, 2'd0);
        goto(14); pll_locked = 1'b1;
        goto(20);
        apply_reset();
        // Lock already present: lk_s is 1 from edge 2, STABLE from 5, RUN at 13.
        expect_at("post_rst_wait",    4, 0, 1, 0, 0, 0, 2'd0);
        expect_at("post_rst_pre_run", 12, 0, 1, 0, 0, 0, 2'd0);
        expect_at("post_rst_run",     13, 0, 0, 1, 0, 0, 2'd0);
        goto(13);
        wait_drain(10);
    endtask

    initial begin
        @(negedge refclk);
        test_reset();
        test_clean_lock();
        test_glitchy_lock();
        test_timeout_persists();
        test_never_lock_and_restart();
        test_loss_in_run();
        test_rst_in_stable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
